// File: rtl/regfile_bist_seq.sv
// regfile_bist_seq: built-in self-test sequencer for an 8x16 (by default) register file.
// It writes pat(a) = SEED + a*0x0101 to every address. It then reads all addresses back,
// ascending on port R and descending on port S, and checks each read against the pattern.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              one-cycle run request, honoured only while idle
//   busy, done         run in progress / one-cycle "result final" pulse
//   pass               last run had no mismatches (held until next start)
//   err_count          total mismatches over both ports, saturating
//   err_addr           R-port address of the first mismatch (0 if none)
//   we, W_Adr, W       register-file write port
//   R_Adr, S_Adr       register-file read addresses
//   R, S               register-file read data (combinational from the addresses)
module regfile_bist_seq #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16,
  parameter logic [DATA_W-1:0] SEED = 16'hA500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic              we,
  output logic [ADDR_W-1:0] W_Adr,
  output logic [DATA_W-1:0] W,
  output logic [ADDR_W-1:0] R_Adr,
  output logic [ADDR_W-1:0] S_Adr,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] S
);

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] PatStep  = DATA_W'(16'h0101);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StFin} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_a;
  logic                r_busy, r_done, r_pass, r_we, r_cmp_valid;
  logic [ADDR_W+1:0]   r_err_count;
  logic [ADDR_W-1:0]   r_err_addr, r_w_adr, r_r_adr, r_s_adr;
  logic [DATA_W-1:0]   r_w, r_exp_r, r_exp_s;

  logic                w_mis_r, w_mis_s;
  logic [ADDR_W+2:0]   w_sum;
  logic [ADDR_W+1:0]   w_err_next;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return SEED + DATA_W'(a) * PatStep;
  endfunction

  // Compare stage: one cycle behind the address issue, using the registered expectations.
  always_comb begin
    w_mis_r    = r_cmp_valid && (R != r_exp_r);
    w_mis_s    = r_cmp_valid && (S != r_exp_s);
    w_sum      = {1'b0, r_err_count} + (ADDR_W+3)'(w_mis_r) + (ADDR_W+3)'(w_mis_s);
    w_err_next = w_sum[ADDR_W+2] ? {(ADDR_W+2){1'b1}} : w_sum[ADDR_W+1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_we        <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
      r_w_adr     <= '0;
      r_w         <= '0;
      r_r_adr     <= '0;
      r_s_adr     <= '0;
      r_exp_r     <= '0;
      r_exp_s     <= '0;
    end else begin
      r_done      <= 1'b0;
      r_cmp_valid <= 1'b0;

      if (w_mis_r || w_mis_s) begin
        r_err_count <= w_err_next;
        // First mismatch of the run; counter is cleared at start and never wraps to 0.
        if (r_err_count == '0) r_err_addr <= r_r_adr;
      end

      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StWrite;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_a         <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
          end
        end
        StWrite: begin
          r_we    <= 1'b1;
          r_w_adr <= r_a;
          r_w     <= pat(r_a);
          r_a     <= r_a + 1'b1;
          if (r_a == LastAddr) begin
            r_state <= StRead;
            r_a     <= '0;
          end
        end
        StRead: begin
          r_we        <= 1'b0;
          r_r_adr     <= r_a;
          r_s_adr     <= ~r_a;  // DEPTH-1-a for a power-of-two depth
          r_exp_r     <= pat(r_a);
          r_exp_s     <= pat(~r_a);
          r_cmp_valid <= 1'b1;
          r_a         <= r_a + 1'b1;
          if (r_a == LastAddr) r_state <= StDrain;
        end
        StDrain: begin
          r_state <= StFin;
        end
        StFin: begin
          r_done  <= 1'b1;
          r_pass  <= (r_err_count == '0);
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;
  assign we        = r_we;
  assign W_Adr     = r_w_adr;
  assign W         = r_w;
  assign R_Adr     = r_r_adr;
  assign S_Adr     = r_s_adr;

endmodule

// File: tb/tb_regfile_bist_seq.sv
module tb_regfile_bist_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, we;
  logic [4:0]  err_count;
  logic [2:0]  err_addr, W_Adr, R_Adr, S_Adr;
  logic [15:0] W, R, S;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;  // 0 good, 1 addr3 bit0 stuck-0, 2 addr5 ignores writes, 3 always FFFF

  logic [15:0] mem [8];
  logic [15:0] exp_pat [8];

  always #5 clk = ~clk;

  regfile_bist_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .err_addr  (err_addr),
    .we        (we),
    .W_Adr     (W_Adr),
    .W         (W),
    .R_Adr     (R_Adr),
    .S_Adr     (S_Adr),
    .R         (R),
    .S         (S)
  );

  // Register-file model with injectable faults.
  always @(posedge clk) if (we) mem[W_Adr] <= W;

  always_comb begin
    R = mem[R_Adr];
    S = mem[S_Adr];
    case (mode)
      1: begin
        if (R_Adr == 3'd3) R[0] = 1'b0;
        if (S_Adr == 3'd3) S[0] = 1'b0;
      end
      2: begin
        if (R_Adr == 3'd5) R = 16'h0000;
        if (S_Adr == 3'd5) S = 16'h0000;
      end
      3: begin
        R = 16'hFFFF;
        S = 16'hFFFF;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run and watches 24 cycles after the start edge.
  task automatic run(input int restart_at, input int exp_err, input int exp_eaddr,
                     input logic exp_pass);
    int wr;
    int dn;
    int dcyc;
    wr = 0; dn = 0; dcyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", busy, 1);
    check("pass_clr", pass, 0);
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (we) begin
        if (wr < 8) begin
          check("w_adr", W_Adr, wr);
          check("w_dat", W, exp_pat[wr]);
        end
        wr++;
      end
      if (done) begin
        dn++;
        if (dcyc == 0) dcyc = n;
      end
      if (n == restart_at) start = 1'b1;
    end
    check("we_cycles", wr, 8);
    check("done_cyc", dcyc, 18);
    check("done_cnt", dn, 1);
    check("pass", pass, exp_pass);
    check("err_count", err_count, exp_err);
    check("err_addr", err_addr, exp_eaddr);
    check("busy_off", busy, 0);
  endtask

  initial begin
    exp_pat = '{16'hA500, 16'hA601, 16'hA702, 16'hA803,
                16'hA904, 16'hAA05, 16'hAB06, 16'hAC07};
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_eaddr", err_addr, 0);
    check("rst_we", we, 0);
    check("rst_wadr", W_Adr, 0);
    check("rst_w", W, 0);
    check("rst_radr", R_Adr, 0);
    check("rst_sadr", S_Adr, 0);

    mode = 0; run(0, 0, 0, 1'b1);
    check("mem_hold3", mem[3], 16'hA803);
    check("mem_hold7", mem[7], 16'hAC07);
    mode = 1; run(0, 2, 3, 1'b0);
    mode = 2; run(0, 2, 2, 1'b0);
    mode = 0; run(5, 0, 0, 1'b1);  // start pulse sampled at cycle 6 must be ignored
    mode = 3; run(0, 16, 0, 1'b0);

    // Reset during READ.
    mode = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    check("mid_err", err_count, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_busy", busy, 0);
    check("mr_we", we, 0);
    check("mr_err", err_count, 0);
    check("mr_done", done, 0);
    reset = 1'b0;
    begin
      int dn;
      dn = 0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (done) dn++;
      end
      check("mr_nodone", dn, 0);
    end
    mode = 0; run(0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
